prog_ctr_stack: RTL and testbench
=================================

# prog_ctr_stack

Parametrised next-generation program counter for the fetch stage. Holds the instruction address, advances it by one per cycle while running, and supports conditional absolute/relative branches, unconditional subroutine call/return through an internal return-address stack, pipeline stall, and halt. A small run-control state machine gates execution with `Start` and reports completion and stack faults to the top level.

## Interface
- `PC_W`, 10: program counter width in bits; `Target` width matches.
- `STACK_DEPTH`, 4: return-address stack entries (>= 1).
- `SP_W`, $clog2(STACK_DEPTH+1): width of `StackCount`; derived, do not override.

- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  level-sampled; starts or restarts execution from address 0.
- `Stall`  in  1  hold PC and stack this cycle.
- `BranchAbsEn`  in  1  absolute branch request, taken only if `ALU_flag`.
- `BranchRelEn`  in  1  relative branch request, taken only if `ALU_flag`.
- `ALU_flag`  in  1  branch condition.
- `CallEn`  in  1  unconditional call: push return address, jump to `Target`.
- `RetEn`  in  1  unconditional return: pop stack into PC.
- `HaltEn`  in  1  stop execution at current PC.
- `Target`  in  PC_W  absolute address (abs/call) or two's-complement offset (rel).
- `ProgCtr`  out  PC_W  current instruction address.
- `Running`  out  1  high in RUN state.
- `Done`  out  1  high in DONE state.
- `Fault`  out  1  high in FAULT state.
- `StackCount`  out  SP_W  number of valid stack entries.

## Operation
- States: IDLE, RUN, DONE, FAULT. `Running`/`Done`/`Fault` are one-hot decodes of RUN/DONE/FAULT; IDLE drives all three low.
- IDLE: `ProgCtr` = 0, stack empty. `Start`=1 -> RUN, PC stays 0.
- DONE, FAULT: PC and stack frozen. `Start`=1 -> RUN with PC=0, `StackCount`=0.
- RUN: per-cycle action, strict priority (first match wins):
  1. `Start`: restart, PC=0, stack cleared, stay RUN.
  2. `Stall`: no change to PC, stack or state; all other controls ignored.
  3. `HaltEn`: PC holds, -> DONE.
  4. `RetEn`: if `StackCount`=0 -> FAULT, PC holds; else PC = top entry, `StackCount`-1.
  5. `CallEn`: if `StackCount`=STACK_DEPTH -> FAULT, PC holds; else push PC+1 (mod 2^PC_W), PC=`Target`, `StackCount`+1.
  6. `BranchAbsEn` & `ALU_flag`: PC=`Target`.
  7. `BranchRelEn` & `ALU_flag`: PC = PC + sign-extended `Target`, modulo 2^PC_W.
  8. otherwise PC = PC+1, modulo 2^PC_W (2^PC_W-1 wraps to 0).
- Branch enables with `ALU_flag`=0 fall through to increment.
- Stack is LIFO; entries not cleared on pop, only `StackCount` moves; contents beyond `StackCount` are don't-care.
- Controls other than `Start` are ignored outside RUN.

## Timing
- Reset (synchronous, highest priority over all inputs including `Start`): next edge gives state=IDLE, `ProgCtr`=0, `StackCount`=0, `Running`=`Done`=`Fault`=0. Reset mid-operation discards stack and state identically.
- All outputs are registered; controls sampled at edge N take effect on `ProgCtr`/flags visible after edge N (one-cycle latency, no combinational input-to-output path).
- `Start` at edge N from IDLE: `Running`=1 after N, `ProgCtr`=0; first increment at edge N+1 -> 1.
- Fault/halt: the flag asserts after the same edge that detects the condition; `ProgCtr` shows the address of the faulting/halting instruction.
- Stall in IDLE/DONE/FAULT has no effect; `Start` there still acts.

## Test plan
- Reset then idle: assert `Reset` 1 cycle, `Start`=0 for 5 cycles -> `ProgCtr`=0, `Running`=0 throughout, `StackCount`=0.
- Run and wrap (PC_W=4): `Start` pulse, 17 free cycles -> `ProgCtr` 0,1,...,15,0,1; `Running`=1.
- Branches: at PC=5, `BranchAbsEn`, `ALU_flag`=1, `Target`=12 -> 12; at 12, `BranchRelEn`, `Target`=-3 (all ones minus 2) -> 9; at 9, `BranchAbsEn`, `ALU_flag`=0 -> 10.
- Call/return nest (STACK_DEPTH=2): at PC=3 call `Target`=20 -> 20, count 1; at 20 call 40 -> 40, count 2; at 40 call 60 -> `Fault`=1, PC=40; `Start` -> PC=0, count 0, RUN; repeat two calls then two `RetEn` -> PCs 41→21, then 4; extra `RetEn` -> `Fault`=1.
- Stall and priority: at PC=7 assert `Stall` with `HaltEn` and `CallEn` for 3 cycles -> PC=7, count unchanged; release with `HaltEn`+`RetEn` -> `Done`=1, PC=7.
- Reset mid-run: count 2, PC=33, assert `Reset` with `Start`=1 -> next edge IDLE, PC=0, `StackCount`=0, all flags 0.

Source files
------------

// File: rtl/prog_ctr_stack.sv
// Fetch-stage program counter with run-control FSM and a return-address stack.
// Supports conditional abs/rel branches, call/return, stall, halt and fault reporting.
module prog_ctr_stack #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            BranchAbsEn,
    input  logic            BranchRelEn,
    input  logic            ALU_flag,
    input  logic            CallEn,
    input  logic            RetEn,
    input  logic            HaltEn,
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic            Fault,
    output logic [SP_W-1:0] StackCount
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t          state;
    logic [PC_W-1:0] stack [STACK_DEPTH];

    logic [PC_W-1:0]  pc_inc_c;
    logic             stack_full_c;
    logic             stack_empty_c;
    logic [IDX_W-1:0] push_idx_c;
    logic [IDX_W-1:0] top_idx_c;
    logic             push_c;

    // Stack bookkeeping; a push happens only when a call wins priority and fits.
    always_comb begin
        pc_inc_c      = ProgCtr + PC_W'(1);
        stack_full_c  = (StackCount == SP_W'(STACK_DEPTH));
        stack_empty_c = (StackCount == '0);
        push_idx_c    = IDX_W'(StackCount);
        top_idx_c     = IDX_W'(StackCount - SP_W'(1));
        push_c        = (state == RUN) && !Start && !Stall && !HaltEn && !RetEn
                        && CallEn && !stack_full_c;
    end

    // Entries are never cleared; only StackCount marks which are valid.
    always_ff @(posedge Clk) begin
        if (push_c) begin
            stack[push_idx_c] <= pc_inc_c;
        end
    end

    // Run-control FSM; flags are registered alongside every state change.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state                   <= IDLE;
            ProgCtr                 <= '0;
            StackCount              <= '0;
            {Running, Done, Fault}  <= 3'b000;
        end else begin
            case (state)
                IDLE, DONE, FAULT: begin
                    if (Start) begin
                        state                  <= RUN;
                        ProgCtr                <= '0;
                        StackCount             <= '0;
                        {Running, Done, Fault} <= 3'b100;
                    end
                end
                RUN: begin
                    if (Start) begin
                        ProgCtr    <= '0;
                        StackCount <= '0;
                    end else if (Stall) begin
                        ProgCtr <= ProgCtr;
                    end else if (HaltEn) begin
                        state                  <= DONE;
                        {Running, Done, Fault} <= 3'b010;
                    end else if (RetEn) begin
                        if (stack_empty_c) begin
                            state                  <= FAULT;
                            {Running, Done, Fault} <= 3'b001;
                        end else begin
                            ProgCtr    <= stack[top_idx_c];
                            StackCount <= StackCount - SP_W'(1);
                        end
                    end else if (CallEn) begin
                        if (stack_full_c) begin
                            state                  <= FAULT;
                            {Running, Done, Fault} <= 3'b001;
                        end else begin
                            ProgCtr    <= Target;
                            StackCount <= StackCount + SP_W'(1);
                        end
                    end else if (BranchAbsEn && ALU_flag) begin
                        ProgCtr <= Target;
                    end else if (BranchRelEn && ALU_flag) begin
                        // Same-width add wraps, which equals adding the sign-extended offset.
                        ProgCtr <= ProgCtr + Target;
                    end else begin
                        ProgCtr <= pc_inc_c;
                    end
                end
                default: begin
                    state                  <= IDLE;
                    ProgCtr                <= '0;
                    StackCount             <= '0;
                    {Running, Done, Fault} <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr_stack.sv
// Scoreboard bench for prog_ctr_stack: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_prog_ctr_stack;

    localparam int unsigned PC_W  = 6;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int          MOD   = 1 << PC_W;

    logic            Clk;
    logic            Reset;
    logic            Start;
    logic            Stall;
    logic            BranchAbsEn;
    logic            BranchRelEn;
    logic            ALU_flag;
    logic            CallEn;
    logic            RetEn;
    logic            HaltEn;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic            Running;
    logic            Done;
    logic            Fault;
    logic [SP_W-1:0] StackCount;

    prog_ctr_stack #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .ALU_flag(ALU_flag),
        .CallEn(CallEn), .RetEn(RetEn), .HaltEn(HaltEn), .Target(Target),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .Fault(Fault),
        .StackCount(StackCount)
    );

    typedef enum {M_IDLE, M_RUN, M_DONE, M_FAULT} mstate_t;
    typedef struct {
        int pc;
        bit running;
        bit done;
        bit fault;
        int count;
    } exp_t;

    exp_t    exp_q[$];
    mstate_t m_state;
    int      m_pc;
    int      m_stack[$];
    int      checks;
    int      errors;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: one call per clock edge, in terms of the architectural rules.
    task automatic model_step(bit rst, bit st, bit stl, bit halt, bit ret, bit call,
                              bit babs, bit brel, bit flag, int tgt);
        if (rst) begin
            m_state = M_IDLE;
            m_pc    = 0;
            m_stack.delete();
        end else if (m_state != M_RUN) begin
            if (st) begin
                m_state = M_RUN;
                m_pc    = 0;
                m_stack.delete();
            end
        end else if (st) begin
            m_pc = 0;
            m_stack.delete();
        end else if (stl) begin
            m_pc = m_pc;
        end else if (halt) begin
            m_state = M_DONE;
        end else if (ret) begin
            if (m_stack.size() == 0) m_state = M_FAULT;
            else m_pc = m_stack.pop_back();
        end else if (call) begin
            if (m_stack.size() == DEPTH) m_state = M_FAULT;
            else begin
                m_stack.push_back((m_pc + 1) % MOD);
                m_pc = tgt;
            end
        end else if (babs && flag) begin
            m_pc = tgt;
        end else if (brel && flag) begin
            m_pc = (m_pc + tgt) % MOD;
        end else begin
            m_pc = (m_pc + 1) % MOD;
        end
    endtask

    task automatic step(bit rst, bit st, bit stl, bit halt, bit ret, bit call,
                        bit babs, bit brel, bit flag, int tgt);
        exp_t e;
        @(negedge Clk);
        Reset       = rst;
        Start       = st;
        Stall       = stl;
        HaltEn      = halt;
        RetEn       = ret;
        CallEn      = call;
        BranchAbsEn = babs;
        BranchRelEn = brel;
        ALU_flag    = flag;
        Target      = PC_W'(tgt);
        model_step(rst, st, stl, halt, ret, call, babs, brel, flag, tgt);
        e.pc      = m_pc;
        e.running = (m_state == M_RUN);
        e.done    = (m_state == M_DONE);
        e.fault   = (m_state == M_FAULT);
        e.count   = m_stack.size();
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic start_run();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic advance_to(int p);
        for (int i = 0; i < 4 * MOD && m_pc != p; i++) idle(1);
        if (m_pc != p) begin
            checks++;
            errors++;
            $display("FAIL advance_to: model pc %0d never reached required %0d", m_pc, p);
        end
    endtask

    // Monitor: every registered output update is compared with the oldest expectation.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ProgCtr !== PC_W'(e.pc) || Running !== e.running || Done !== e.done ||
                Fault !== e.fault || StackCount !== SP_W'(e.count)) begin
                errors++;
                $display("FAIL cycle_check @%0t: got pc=%0d run=%b done=%b fault=%b cnt=%0d, want pc=%0d run=%b done=%b fault=%b cnt=%0d",
                         $time, ProgCtr, Running, Done, Fault, StackCount,
                         e.pc, e.running, e.done, e.fault, e.count);
            end
        end
    end

    initial begin
        bit rst, st, stl, halt, ret, call, babs, brel, flag;
        checks  = 0;
        errors  = 0;
        m_state = M_IDLE;
        m_pc    = 0;
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; HaltEn = 1'b0; RetEn = 1'b0;
        CallEn = 1'b0; BranchAbsEn = 1'b0; BranchRelEn = 1'b0; ALU_flag = 1'b0;
        Target = '0;

        // Reset then idle
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Run and wrap through 2^PC_W
        start_run();
        idle(MOD + 2);

        // Branches
        advance_to(5);
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 12);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, MOD - 3);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 30);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 30);

        // Call nest overflow, restart, then underflow
        start_run();
        advance_to(3);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 20);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 40);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 60);
        idle(2);
        start_run();
        advance_to(3);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 20);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 40);
        idle(1);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0, 0, 0, 9);

        // Stall priority, then halt beating return
        start_run();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 5);
        advance_to(7);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 1, 1, 1, 1, 50);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Reset mid-run with Start held
        start_run();
        advance_to(3);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 30);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 33);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(199) == 0);
            st   = ($urandom_range(39) == 0) || (m_state != M_RUN && $urandom_range(3) == 0);
            stl  = ($urandom_range(5) == 0);
            halt = ($urandom_range(49) == 0);
            ret  = ($urandom_range(6) == 0);
            call = ($urandom_range(6) == 0);
            babs = ($urandom_range(5) == 0);
            brel = ($urandom_range(5) == 0);
            flag = $urandom_range(1) == 1;
            step(rst, st, stl, halt, ret, call, babs, brel, flag, int'($urandom_range(MOD - 1)));
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
